// File: rtl/line_buf_ctrl_pkg.sv
// rtl/line_buf_ctrl_pkg.sv - shared state encoding and constants for the line buffer sequencer
package line_buf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LBRST = 3'd1,
        CLEAR = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int WIN_ROWS       = 5;
    // Rows that only fill the four buffer taps before a full column exists
    localparam int PRIME_ROWS     = WIN_ROWS - 1;
    localparam int DEF_LINE_WIDTH = 114;
    localparam int DEF_ADDR_W     = 9;

endpackage

// File: rtl/lb_pos_cnt.sv
// rtl/lb_pos_cnt.sv - column/row position counter with line wrap and last-pixel flag
module lb_pos_cnt
    import line_buf_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int COL_W      = DEF_ADDR_W,
    parameter int ROW_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [ROW_W-1:0] rows,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (inc) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = (r_col == LAST_COL) && (r_row == rows - ROW_W'(1));

endmodule

// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - frame sequencer for the 4-line SRAM line buffer; optional LINE_BUF_CTRL_STALL_GUARD_EN
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ROW_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    output logic              in_ready,
    output logic              lb_rst,
    output logic              lb_en,
    output logic [PIX_W-1:0]  lb_wdata,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [ROW_W-1:0]  win_row,
    output logic              busy,
    output logic              frame_done,
    output logic              stall_err
);

    localparam int CLR_W = $clog2(LINE_WIDTH);

    state_t           r_state;
    logic             r_lb_rst;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_frame_done;
    logic [ROW_W-1:0] r_rows;
    logic [CLR_W-1:0] r_clr_cnt;

    logic             w_xfer;
    logic             w_last;
    logic             w_cnt_clr;

    assign w_xfer    = in_valid & r_in_ready;
    assign w_cnt_clr = (r_state == LBRST);

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lb_rst     <= 1'b1;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rows       <= '0;
            r_clr_cnt    <= '0;
        end else begin
            r_lb_rst     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LBRST;
                        r_lb_rst <= 1'b1;
                        r_busy   <= 1'b1;
                        r_rows   <= cfg_rows;
                    end
                end
                LBRST: begin
                    r_state   <= CLEAR;
                    r_clr_cnt <= '0;
                end
                CLEAR: begin
                    if (r_clr_cnt == CLR_W'(LINE_WIDTH - 1)) begin
                        r_state    <= RUN;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                    end
                end
                RUN: begin
                    if (w_xfer && w_last) begin
                        r_state      <= DONE;
                        r_in_ready   <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    lb_pos_cnt #(
        .LINE_WIDTH(LINE_WIDTH),
        .COL_W     (ADDR_W),
        .ROW_W     (ROW_W)
    ) u_pos_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_cnt_clr),
        .inc  (w_xfer),
        .rows (r_rows),
        .col  (win_col),
        .row  (win_row),
        .last (w_last)
    );

    assign in_ready   = r_in_ready;
    assign lb_rst     = r_lb_rst;
    assign lb_en      = w_xfer;
    assign lb_wdata   = w_xfer ? in_data : '0;
    assign win_valid  = w_xfer && (win_row >= ROW_W'(PRIME_ROWS));
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

`ifdef LINE_BUF_CTRL_STALL_GUARD_EN
    logic [ADDR_W-1:0] r_shadow;
    logic              r_stall_err;
    logic              w_stall;
    logic              w_shadow_inc;

    assign w_stall      = r_in_ready & ~in_valid;
    assign w_shadow_inc = (r_state == CLEAR) || w_stall;

    // A stall seen with the shadow at 0 means the buffer's rst_addr has lapped into live data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_stall_err <= 1'b0;
            end else if (w_stall && r_shadow == '0) begin
                r_stall_err <= 1'b1;
            end
            if (r_state == LBRST) begin
                r_shadow <= '0;
            end else if (w_shadow_inc) begin
                r_shadow <= r_shadow + ADDR_W'(1);
            end
        end
    end

    assign stall_err = r_stall_err;
`else
    assign stall_err = 1'b0;
`endif

endmodule
